// File: rtl/aes_pkg.sv
// Shared AES byte-substitution types, forward/inverse S-box tables and byte accessor.
// The tables are full bijections over 0x00..0xff.
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [127:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } eng_state_e;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic byte_t get_byte(input state_t s, input int idx);
      return s[idx*8 +: 8];
   endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse lookup selected by 'inverse'.
// No state, no handshake; latency 0.
module sbox_lane
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   input  logic       inverse,
   output logic [7:0] out_byte
);

   assign out_byte = inverse ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes over a 128-bit state, LANES bytes per cycle, valid/ready on both sides.
// SBOX_PIPE_EN adds a register between lookup and write-back (latency STEPS+1 instead of STEPS).
module sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int LANES = 4
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inverse,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int STEPS = 16 / LANES;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t LAST = cnt_t'(STEPS - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   eng_state_e             state_q, state_d;
   cnt_t                   cnt_q, cnt_d;
   state_t                 work_q, work_d;
   logic                   mode_q, mode_d;
   logic [LANES*8-1:0]     lane_in, lane_out;
   logic                   accept;
   logic                   look_en;
   logic                   wr_en;
   cnt_t                   wr_idx;
   logic [LANES*8-1:0]     wr_dat;
   logic                   last_wr;

   assign accept = (state_q == ST_IDLE) && in_valid;

   always_comb begin
      lane_in = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_in[l*8 +: 8] = get_byte(work_q, int'(cnt_q) * LANES + l);
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      sbox_lane u_lane (
         .in_byte  (lane_in[g*8 +: 8]),
         .inverse  (mode_q),
         .out_byte (lane_out[g*8 +: 8])
      );
   end

`ifdef SBOX_PIPE_EN
   logic               pipe_vld_q, pipe_vld_d;
   cnt_t               pipe_idx_q, pipe_idx_d;
   logic [LANES*8-1:0] pipe_dat_q, pipe_dat_d;
   logic               look_done_q, look_done_d;

   assign look_en = (state_q == ST_RUN) && !look_done_q;
   assign wr_en   = pipe_vld_q;
   assign wr_idx  = pipe_idx_q;
   assign wr_dat  = pipe_dat_q;
   assign last_wr = pipe_vld_q && (pipe_idx_q == LAST);

   always_comb begin
      pipe_vld_d  = look_en;
      pipe_idx_d  = look_en ? cnt_q : pipe_idx_q;
      pipe_dat_d  = look_en ? lane_out : pipe_dat_q;
      look_done_d = look_done_q;
      if (state_q != ST_RUN) begin
         look_done_d = 1'b0;
      end else if (look_en && cnt_q == LAST) begin
         look_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_vld_q  <= 1'b0;
         pipe_idx_q  <= '0;
         pipe_dat_q  <= '0;
         look_done_q <= 1'b0;
      end else begin
         pipe_vld_q  <= pipe_vld_d;
         pipe_idx_q  <= pipe_idx_d;
         pipe_dat_q  <= pipe_dat_d;
         look_done_q <= look_done_d;
      end
   end
`else
   assign look_en = (state_q == ST_RUN);
   assign wr_en   = look_en;
   assign wr_idx  = cnt_q;
   assign wr_dat  = lane_out;
   assign last_wr = look_en && (cnt_q == LAST);
`endif

   // Datapath: load on accept, otherwise advance the lookup slice and write results back in place.
   always_comb begin
      cnt_d  = cnt_q;
      work_d = work_q;
      mode_d = mode_q;
      if (accept) begin
         cnt_d  = '0;
         work_d = in_state;
         mode_d = in_inverse;
      end else begin
         if (look_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_t'(cnt_q + 1'b1);
         end
         if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
               work_d[(int'(wr_idx) * LANES + l) * 8 +: 8] = wr_dat[l*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         work_q <= '0;
         mode_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         work_q <= work_d;
         mode_q <= mode_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (last_wr)   state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      out_state = work_q;
   end

endmodule
